pmod_ledbtn_dbn: RTL and testbench
==================================

PMOD_LEDBTN_DBN -- requirements
Module: pmod_ledbtn_dbn

Interface
REQ-001 SHALL have parameter N_LED, default 5: number of LED outputs, legal range 1..7.
REQ-002 SHALL have parameter N_BTN, default 3: number of button inputs, legal range 1..7.
REQ-003 SHALL have parameter DB_CYCLES, default 120000: debounce stable-time in CLK cycles (10 ms at 12 MHz), legal range 2..2^24-1.
REQ-004 SHALL have port CLK, input, width 1: single system clock; all logic on its rising edge.
REQ-005 SHALL have port RST_N, input, width 1: asynchronous reset, active-low.
REQ-006 SHALL have port RX_DATA, input, width 8: command byte from the serial link.
REQ-007 SHALL have port RX_VALID, input, width 1: one-cycle strobe qualifying RX_DATA.
REQ-008 SHALL have port TX_DATA, output, width 8: report byte to the serial link.
REQ-009 SHALL have port TX_VALID, output, width 1: TX_DATA valid, held until accepted.
REQ-010 SHALL have port TX_READY, input, width 1: link accepts a byte when TX_VALID and TX_READY are both high.
REQ-011 SHALL have port LED, output, width N_LED: active-high LED drives.
REQ-012 SHALL have port BTN, input, width N_BTN: raw asynchronous active-high buttons.

Function
REQ-013 SHALL pass each BTN bit through a 2-flop synchroniser before any other use.
REQ-014 SHALL give each button its own counter: reset to 0 whenever the synchronised input equals the debounced level; increment otherwise.
REQ-015 SHALL update the debounced level on the cycle the counter reaches DB_CYCLES-1, and clear the counter on that cycle.
REQ-016 SHALL set a sticky press flag for a button on the cycle its debounced level goes 0->1; release (1->0) SHALL NOT set a flag.
REQ-017 SHALL decode RX_DATA only in a cycle with RX_VALID=1; bytes outside the codes below SHALL be ignored.
REQ-018 SHALL decode RX_DATA[7]=0 as an LED write: LED <= RX_DATA[N_LED-1:0] on the next edge; higher bits ignored.
REQ-019 SHALL decode 8'h80 as a flag read: queue report byte {1'b1, 7'(press flags)}, unused bits 0.
REQ-020 SHALL decode 8'h81 as a level read: queue report byte {1'b0, 7'(debounced levels)}, unused bits 0.
REQ-021 SHALL implement the TX state machine as IDLE -> SEND on a queued report, and SEND -> IDLE on accept (TX_VALID & TX_READY).
REQ-022 SHALL sample report contents into TX_DATA on entry to SEND and hold TX_DATA stable until accept.
REQ-023 SHALL assert TX_VALID one cycle after the command strobe; if TX_READY is high, the minimum latency from strobe to accept is 1 cycle.
REQ-024 SHALL clear exactly the flag bits carried in an accepted flag-read report, in the accept cycle.
REQ-025 SHALL give set priority when a flag set and a flag clear for the same bit occur in the same cycle; the press stays flagged.
REQ-026 SHALL hold one pending read request while in SEND; it SHALL be issued on the cycle after accept.
REQ-027 SHALL drop further read requests while a request is already pending.
REQ-028 SHALL give LED writes no back-pressure: they apply in any TX state.

Reset
REQ-029 SHALL, while RST_N=0, force LED=0, TX_VALID=0, TX_DATA=8'h00, state IDLE, pending=0, all flags, debounced levels, counters and synchroniser flops to 0.
REQ-030 SHALL abort a report in SEND when reset asserts mid-transfer; the report SHALL NOT be resent after reset.
REQ-031 SHALL ignore RX_VALID in the first cycle after RST_N deasserts.

Configuration
REQ-032 SHALL, with LEDBTN_AUTOREPORT_EN defined, queue a flag-read report automatically when any press flag sets while in IDLE with no pending request; the report is identical to one requested by 8'h80.
REQ-033 SHALL, without LEDBTN_AUTOREPORT_EN, emit reports only in response to 8'h80 or 8'h81.

Verification
REQ-034 SHALL cover: DB_CYCLES=4, BTN[0] pulsed high 3 cycles -> no level change, no flag; held 6 cycles -> level[0]=1, flag[0]=1.
REQ-035 SHALL cover: RX_DATA=8'h15 strobed -> LED=5'b10101 next edge; then 8'h9F (bit7=1, unused code) -> LED unchanged, no TX.
REQ-036 SHALL cover: flags=3'b101, 8'h80 with TX_READY=1 -> TX_DATA=8'h85 accepted; next 8'h80 -> 8'h80.
REQ-037 SHALL cover: TX_READY=0 for 10 cycles after 8'h81, then 8'h80 strobed -> TX_DATA stable for all 10 cycles; flag report issued the cycle after the first accept.
REQ-038 SHALL cover: BTN[1] press completing in the same cycle as a flag-report accept -> flag[1] remains 1.
REQ-039 SHALL cover: RST_N low during SEND -> TX_VALID=0 within the reset cycle; no report after release.

Source files
------------

// File: rtl/pmod_ledbtn_dbn_if.sv
// Serial-link side of the LED/button PMOD block: a command byte stream in and
// a report byte stream out.
//
// Handshake: RX_VALID is a one-cycle strobe qualifying RX_DATA; the device
// never stalls the receive side. On the transmit side the device raises
// TX_VALID with TX_DATA and holds both steady until the link has TX_READY high
// on a rising edge; the byte is transferred on that edge (TX_VALID & TX_READY).
interface pmod_ledbtn_dbn_if;
    logic [7:0] RX_DATA;
    logic       RX_VALID;
    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       TX_READY;

    // Link side: sends commands, receives reports.
    modport master (
        output RX_DATA,
        output RX_VALID,
        output TX_READY,
        input  TX_DATA,
        input  TX_VALID
    );

    // Device side: receives commands, sends reports.
    modport slave (
        input  RX_DATA,
        input  RX_VALID,
        input  TX_READY,
        output TX_DATA,
        output TX_VALID
    );
endinterface

// File: rtl/pmod_ledbtn_dbn.sv
// LED / button PMOD controller with per-button debounce, sticky press flags
// and a byte-command link.
//
// Commands (RX_VALID strobe):
//   0xxx_xxxx : LED write, LED <= low N_LED bits
//   8'h80     : flag read,  report {1'b1, press flags}, clears reported flags
//   8'h81     : level read, report {1'b0, debounced levels}
//   others    : ignored
//
// Optional feature: define LEDBTN_AUTOREPORT_EN to queue a flag report on its
// own whenever a press flag sets while the transmitter is idle with nothing
// pending. Without it, reports are sent only in answer to 8'h80 / 8'h81.
//
// state_dbg exposes the transmit FSM state (0 = IDLE, 1 = SEND).
module pmod_ledbtn_dbn #(
    parameter int N_LED     = 5,
    parameter int N_BTN     = 3,
    parameter int DB_CYCLES = 120000
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    pmod_ledbtn_dbn_if.slave     link,
    output logic [N_LED-1:0]     LED,
    input  logic [N_BTN-1:0]     BTN,
    output logic                 state_dbg
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } tx_state_t;

    // Counter compares against the last stable cycle; DB_CYCLES consecutive
    // disagreeing samples are needed before the debounced level flips.
    localparam logic [23:0] CNT_LAST = 24'(DB_CYCLES - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [N_BTN-1:0]        btn_s1;
    logic [N_BTN-1:0]        btn_s2;
    logic [N_BTN-1:0][23:0]  cnt;
    logic [N_BTN-1:0]        lvl;
    logic [N_BTN-1:0]        flags;
    logic                    armed;
    tx_state_t               state;
    logic                    pend;
    logic                    pend_flag;
    logic [7:0]              tx_data;
    logic                    tx_is_flag;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [N_BTN-1:0][23:0]  cnt_nxt;
    logic [N_BTN-1:0]        lvl_nxt;
    logic [N_BTN-1:0]        press_set;
    logic [N_BTN-1:0]        flag_clr;
    logic [N_BTN-1:0]        flags_view;
    logic [N_BTN-1:0]        flags_nxt;
    logic [7:0]              flag_byte;
    logic [7:0]              level_byte;
    logic                    cmd_ok;
    logic                    led_wr;
    logic                    rd_flag;
    logic                    rd_lvl;
    logic                    auto_flag;
    logic                    req_any;
    logic                    req_is_flag;
    logic                    accept;
    tx_state_t               state_nxt;
    logic                    pend_nxt;
    logic                    pend_flag_nxt;
    logic                    issue;
    logic                    issue_flag;

    // Two-flop synchroniser on every raw button input.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
        end else begin
            btn_s1 <= BTN;
            btn_s2 <= btn_s1;
        end
    end

    // Per-button debounce: count disagreeing cycles, flip the level when the
    // count has been held for DB_CYCLES samples.
    always_comb begin
        cnt_nxt = cnt;
        lvl_nxt = lvl;
        for (int i = 0; i < N_BTN; i++) begin
            if (btn_s2[i] == lvl[i]) begin
                cnt_nxt[i] = '0;
            end else if (cnt[i] == CNT_LAST) begin
                cnt_nxt[i] = '0;
                lvl_nxt[i] = btn_s2[i];
            end else begin
                cnt_nxt[i] = cnt[i] + 24'd1;
            end
        end
    end

    // Debounce counters and debounced levels.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt <= '0;
            lvl <= '0;
        end else begin
            cnt <= cnt_nxt;
            lvl <= lvl_nxt;
        end
    end

    // Flag bookkeeping: a rising debounced level sets a flag; an accepted
    // flag report clears exactly the bits it carried; set wins on overlap.
    // Reports sample flags_view / lvl_nxt so a press completing on the
    // sampling edge is already included.
    always_comb begin
        press_set  = lvl_nxt & ~lvl;
        flag_clr   = (accept && tx_is_flag) ? tx_data[N_BTN-1:0] : '0;
        flags_view = flags | press_set;
        flags_nxt  = (flags & ~flag_clr) | press_set;
        flag_byte  = {1'b1, 7'(flags_view)};
        level_byte = {1'b0, 7'(lvl_nxt)};
    end

    // Sticky press flags.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            flags <= '0;
        end else begin
            flags <= flags_nxt;
        end
    end

    // Command gate: RX_VALID is not trusted on the first edge out of reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    // Command decode and read-request sources.
    always_comb begin
        cmd_ok  = link.RX_VALID & armed;
        led_wr  = cmd_ok & ~link.RX_DATA[7];
        rd_flag = cmd_ok & (link.RX_DATA == 8'h80);
        rd_lvl  = cmd_ok & (link.RX_DATA == 8'h81);
`ifdef LEDBTN_AUTOREPORT_EN
        auto_flag = (|press_set) & (state == S_IDLE) & ~pend;
`else
        auto_flag = 1'b0;
`endif
        req_any     = rd_flag | rd_lvl | auto_flag;
        // An explicit level read takes the slot over a simultaneous auto report.
        req_is_flag = ~rd_lvl;
        accept      = (state == S_SEND) & link.TX_READY;
    end

    // LED register: written in any transmit state, no back-pressure.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            LED <= '0;
        end else if (led_wr) begin
            LED <= link.RX_DATA[N_LED-1:0];
        end
    end

    // Transmit FSM next-state: IDLE issues a pending request first, then a
    // new one; SEND holds one extra request and returns to IDLE on accept.
    always_comb begin
        state_nxt     = state;
        pend_nxt      = pend;
        pend_flag_nxt = pend_flag;
        issue         = 1'b0;
        issue_flag    = 1'b0;
        case (state)
            S_IDLE: begin
                if (pend) begin
                    issue      = 1'b1;
                    issue_flag = pend_flag;
                    pend_nxt   = req_any;
                    if (req_any) begin
                        pend_flag_nxt = req_is_flag;
                    end
                end else if (req_any) begin
                    issue      = 1'b1;
                    issue_flag = req_is_flag;
                end
                if (issue) begin
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (accept) begin
                    state_nxt = S_IDLE;
                end
                if (req_any && !pend) begin
                    pend_nxt      = 1'b1;
                    pend_flag_nxt = req_is_flag;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Transmit FSM state and pending-request registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= S_IDLE;
            pend      <= 1'b0;
            pend_flag <= 1'b0;
        end else begin
            state     <= state_nxt;
            pend      <= pend_nxt;
            pend_flag <= pend_flag_nxt;
        end
    end

    // Report byte captured on entry to SEND and held until accepted.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tx_data    <= 8'h00;
            tx_is_flag <= 1'b0;
        end else if (issue) begin
            tx_data    <= issue_flag ? flag_byte : level_byte;
            tx_is_flag <= issue_flag;
        end
    end

    assign link.TX_DATA  = tx_data;
    assign link.TX_VALID = (state == S_SEND);
    assign state_dbg     = state;

endmodule

// File: tb/tb_pmod_ledbtn_dbn.sv
// Directed bench for pmod_ledbtn_dbn with a short debounce (DB_CYCLES = 4).
// Inputs change and outputs are observed on the falling clock edge.
module tb_pmod_ledbtn_dbn;

    localparam int N_LED = 5;
    localparam int N_BTN = 3;

    logic             CLK;
    logic             RST_N;
    logic [N_LED-1:0] LED;
    logic [N_BTN-1:0] BTN;
    logic             state_dbg;

    int n_cmp;
    int n_err;

    pmod_ledbtn_dbn_if link_if ();

    pmod_ledbtn_dbn #(
        .N_LED     (N_LED),
        .N_BTN     (N_BTN),
        .DB_CYCLES (4)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .link      (link_if),
        .LED       (LED),
        .BTN       (BTN),
        .state_dbg (state_dbg)
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // One-cycle command strobe; returns on the falling edge after the strobe edge.
    task automatic send_cmd(input logic [7:0] b);
        link_if.RX_DATA  = b;
        link_if.RX_VALID = 1'b1;
        tick(1);
        link_if.RX_VALID = 1'b0;
        link_if.RX_DATA  = 8'h00;
    endtask

    // Read with TX_READY already high: report visible one cycle after the
    // strobe, accepted on the following edge.
    task automatic read_report(input string tag, input logic [7:0] cmd, input logic [7:0] exp);
        send_cmd(cmd);
        check({tag, "_valid"}, 32'(link_if.TX_VALID), 32'd1);
        check({tag, "_data"}, 32'(link_if.TX_DATA), 32'(exp));
        tick(1);
        check({tag, "_done"}, 32'(link_if.TX_VALID), 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        RST_N = 1'b0;
        BTN   = '0;
        link_if.RX_DATA  = 8'h00;
        link_if.RX_VALID = 1'b0;
        link_if.TX_READY = 1'b0;

        // Reset state
        tick(3);
        check("rst_led", 32'(LED), 32'd0);
        check("rst_txv", 32'(link_if.TX_VALID), 32'd0);
        check("rst_txd", 32'(link_if.TX_DATA), 32'h00);
        check("rst_state", 32'(state_dbg), 32'd0);

        // Strobe in the first cycle out of reset is ignored
        RST_N = 1'b1;
        send_cmd(8'h1F);
        check("first_cycle_ignored", 32'(LED), 32'd0);

        // LED writes and unused codes
        send_cmd(8'h15);
        check("led_write_15", 32'(LED), 32'h15);
        send_cmd(8'h9F);
        check("unused_code_led", 32'(LED), 32'h15);
        check("unused_code_txv", 32'(link_if.TX_VALID), 32'd0);
        tick(2);
        check("unused_code_txv2", 32'(link_if.TX_VALID), 32'd0);
        send_cmd(8'h7F);
        check("led_high_bits_ignored", 32'(LED), 32'h1F);

        link_if.TX_READY = 1'b1;

        // Short glitch: 3 cycles is below the debounce time
        BTN = 3'b001;
        tick(3);
        BTN = 3'b000;
        tick(10);
        read_report("glitch_lvl", 8'h81, 8'h00);
        read_report("glitch_flag", 8'h80, 8'h80);

        // Held press: level not yet flipped after 5 cycles, flipped after 6
        BTN = 3'b001;
        tick(4);
        read_report("hold5_lvl", 8'h81, 8'h00);
        read_report("hold_lvl", 8'h81, 8'h01);
        read_report("hold_flag", 8'h80, 8'h81);
        read_report("flag_cleared", 8'h80, 8'h80);

        // Release does not flag
        BTN = 3'b000;
        tick(8);
        read_report("rel_lvl", 8'h81, 8'h00);
        read_report("rel_flag", 8'h80, 8'h80);

        // Flags 3'b101
        BTN = 3'b101;
        tick(8);
        BTN = 3'b000;
        tick(8);
        read_report("flag101", 8'h80, 8'h85);
        read_report("flag101_clr", 8'h80, 8'h80);

        // Back-pressure with one pending and one dropped request
        BTN = 3'b010;
        tick(8);
        BTN = 3'b000;
        tick(8);
        BTN = 3'b100;
        tick(8);
        link_if.TX_READY = 1'b0;
        send_cmd(8'h81);
        check("bp_valid0", 32'(link_if.TX_VALID), 32'd1);
        check("bp_data0", 32'(link_if.TX_DATA), 32'h04);
        send_cmd(8'h80);
        check("bp_data1", 32'(link_if.TX_DATA), 32'h04);
        send_cmd(8'h81);
        check("bp_data2", 32'(link_if.TX_DATA), 32'h04);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("bp_hold_valid", 32'(link_if.TX_VALID), 32'd1);
            check("bp_hold_data", 32'(link_if.TX_DATA), 32'h04);
        end
        link_if.TX_READY = 1'b1;
        tick(1);
        check("bp_gap", 32'(link_if.TX_VALID), 32'd0);
        tick(1);
        check("bp_pend_valid", 32'(link_if.TX_VALID), 32'd1);
        check("bp_pend_data", 32'(link_if.TX_DATA), 32'h86);
        tick(1);
        check("bp_pend_done", 32'(link_if.TX_VALID), 32'd0);
        tick(3);
        check("bp_dropped", 32'(link_if.TX_VALID), 32'd0);
        BTN = 3'b000;
        tick(8);

        // Press of BTN[1] completing on the accept edge of a flag report
        BTN = 3'b001;
        tick(8);
        BTN = 3'b000;
        tick(8);
        link_if.TX_READY = 1'b0;
        send_cmd(8'h80);
        check("race_valid", 32'(link_if.TX_VALID), 32'd1);
        check("race_data", 32'(link_if.TX_DATA), 32'h81);
        BTN = 3'b010;
        tick(5);
        link_if.TX_READY = 1'b1;
        tick(1);
        check("race_accepted", 32'(link_if.TX_VALID), 32'd0);
        BTN = 3'b000;
        tick(8);
        read_report("race_flag_kept", 8'h80, 8'h82);
        read_report("race_flag_clr", 8'h80, 8'h80);

        // Reset during SEND
        link_if.TX_READY = 1'b0;
        send_cmd(8'h81);
        check("rst_send_valid", 32'(link_if.TX_VALID), 32'd1);
        RST_N = 1'b0;
        #1;
        check("rst_abort_txv", 32'(link_if.TX_VALID), 32'd0);
        check("rst_abort_txd", 32'(link_if.TX_DATA), 32'h00);
        check("rst_abort_led", 32'(LED), 32'd0);
        tick(2);
        RST_N = 1'b1;
        link_if.TX_READY = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check("no_resend", 32'(link_if.TX_VALID), 32'd0);
        end
        send_cmd(8'h0A);
        check("led_after_reset", 32'(LED), 32'h0A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
